// File: rtl/pass_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pass_pkg
// Brief    : Shared FSM state encoding and default constants for the
//            password authentication engine.
// Revision : 1.0 - initial release
// ============================================================================
package pass_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_ROMWAIT = 3'd3,
        ST_CATCH   = 3'd4,
        ST_COMPARE = 3'd5,
        ST_PASSED  = 3'd6,
        ST_LOCKED  = 3'd7
    } pass_state_t;

    localparam int c_digits       = 4;
    localparam int c_digit_w      = 4;
    localparam int c_id_w         = 5;
    localparam int c_max_attempts = 4;
    localparam int c_rom_lat      = 2;
    localparam int c_lockout_cyc  = 1000;
    localparam int c_timeout_cyc  = 5000;
    localparam int c_timer_w      = $clog2(c_timeout_cyc + 1);

endpackage
`default_nettype wire

// File: rtl/pass_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : pass_cycle_timer
// Brief    : Loadable down-counter; expired is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module pass_cycle_timer
    import pass_pkg::*;
#(
    parameter int WIDTH = c_timer_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pass_auth_engine.sv
`default_nettype none
// ============================================================================
// Module   : pass_auth_engine
// Brief    : Collects a multi-digit password, fetches the stored password from
//            a synchronous ROM word by word, compares, and manages lockout.
// Revision : 1.0 - initial release
// ============================================================================
module pass_auth_engine
    import pass_pkg::*;
#(
    parameter int DIGITS       = c_digits,
    parameter int DIGIT_W      = c_digit_w,
    parameter int ID_W         = c_id_w,
    parameter int MAX_ATTEMPTS = c_max_attempts,
    parameter int ROM_LAT      = c_rom_lat,
    parameter int LOCKOUT_CYC  = c_lockout_cyc,
    parameter int TIMEOUT_CYC  = c_timeout_cyc
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             game_enter,
    input  logic [DIGIT_W-1:0]               user_digit,
    input  logic                             matched_id,
    input  logic [ID_W-1:0]                  internal_id,
    input  logic                             guest,
    input  logic                             gm_logout,
    output logic [ID_W+$clog2(DIGITS)-1:0]   rom_addr,
    input  logic [DIGIT_W-1:0]               rom_data,
    output logic                             login,
    output logic                             logout,
    output logic                             fail,
    output logic                             locked,
    output logic [3:0]                       attempts_left
);

    localparam int c_addr_w  = ID_W + $clog2(DIGITS);
    localparam int c_buf_w   = DIGITS * DIGIT_W;
    localparam int c_cnt_w   = $clog2(DIGITS + 1);
    localparam int c_idx_w   = $clog2(DIGITS);
    localparam int c_tmr_max = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_addr_w-1:0] c_digits_a  = c_addr_w'(DIGITS);
    localparam logic [c_cnt_w-1:0]  c_last_cnt  = c_cnt_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(DIGITS - 1);
    localparam logic [3:0]          c_max_att   = 4'(MAX_ATTEMPTS);
    localparam logic [1:0]          c_wait_init = 2'(ROM_LAT - 2);
    localparam logic [c_tmr_w-1:0]  c_tmo_load  = c_tmr_w'(TIMEOUT_CYC - 1);
    localparam logic [c_tmr_w-1:0]  c_lock_load = c_tmr_w'(LOCKOUT_CYC - 1);

    pass_state_t           r_state, w_state_next;
    logic [ID_W-1:0]       r_id, w_id;
    logic [c_buf_w-1:0]    r_user_buf, w_user_buf;
    logic [c_buf_w-1:0]    r_rom_buf, w_rom_buf;
    logic [c_cnt_w-1:0]    r_digit_cnt, w_digit_cnt;
    logic [c_idx_w-1:0]    r_idx, w_idx;
    logic [1:0]            r_wait, w_wait;
    logic [c_addr_w-1:0]   r_rom_addr, w_rom_addr;
    logic                  r_login, w_login;
    logic                  r_logout, w_logout;
    logic                  r_fail, w_fail;
    logic [3:0]            r_attempts, w_attempts;
    logic                  w_tmr_load, w_tmr_en, w_tmr_expired;
    logic [c_tmr_w-1:0]    w_tmr_value;

    // One timer serves the entry timeout and the lockout hold; the two
    // states never overlap, so each use reloads it on entry.
    pass_cycle_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .enable     (w_tmr_en),
        .expired    (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            r_user_buf  <= '0;
            r_rom_buf   <= '0;
            r_digit_cnt <= '0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_rom_addr  <= '0;
            r_login     <= 1'b0;
            r_logout    <= 1'b0;
            r_fail      <= 1'b0;
            r_attempts  <= c_max_att;
        end else begin
            r_state     <= w_state_next;
            r_id        <= w_id;
            r_user_buf  <= w_user_buf;
            r_rom_buf   <= w_rom_buf;
            r_digit_cnt <= w_digit_cnt;
            r_idx       <= w_idx;
            r_wait      <= w_wait;
            r_rom_addr  <= w_rom_addr;
            r_login     <= w_login;
            r_logout    <= w_logout;
            r_fail      <= w_fail;
            r_attempts  <= w_attempts;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_id         = r_id;
        w_user_buf   = r_user_buf;
        w_rom_buf    = r_rom_buf;
        w_digit_cnt  = r_digit_cnt;
        w_idx        = r_idx;
        w_wait       = r_wait;
        w_rom_addr   = r_rom_addr;
        w_login      = 1'b0;
        w_logout     = 1'b0;
        w_fail       = 1'b0;
        w_attempts   = r_attempts;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;
        w_tmr_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_attempts = c_max_att;
                if (guest) begin
                    w_state_next = ST_PASSED;
                end else if (matched_id) begin
                    w_id         = internal_id;
                    w_user_buf   = '0;
                    w_rom_buf    = '0;
                    w_digit_cnt  = '0;
                    w_state_next = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                // A digit in the expiry cycle wins over the timeout.
                if (game_enter) begin
                    w_user_buf = {r_user_buf[c_buf_w-DIGIT_W-1:0], user_digit};
                    if (r_digit_cnt == c_last_cnt) begin
                        w_digit_cnt  = '0;
                        w_idx        = '0;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_digit_cnt = r_digit_cnt + 1'b1;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = c_tmo_load;
                    end
                end else if (r_digit_cnt != '0) begin
                    if (w_tmr_expired) begin
                        w_user_buf  = '0;
                        w_digit_cnt = '0;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                w_rom_addr = c_addr_w'(r_id) * c_digits_a + c_addr_w'(r_idx);
                if (ROM_LAT == 1) begin
                    w_state_next = ST_CATCH;
                end else begin
                    w_wait       = c_wait_init;
                    w_state_next = ST_ROMWAIT;
                end
            end

            ST_ROMWAIT: begin
                if (r_wait == 2'd0) begin
                    w_state_next = ST_CATCH;
                end else begin
                    w_wait = r_wait - 2'd1;
                end
            end

            // rom_data is sampled on the ROM_LAT-th edge after rom_addr updates.
            ST_CATCH: begin
                w_rom_buf = {r_rom_buf[c_buf_w-DIGIT_W-1:0], rom_data};
                if (r_idx == c_last_idx) begin
                    w_state_next = ST_COMPARE;
                end else begin
                    w_idx        = r_idx + 1'b1;
                    w_state_next = ST_FETCH;
                end
            end

            ST_COMPARE: begin
                if (r_user_buf == r_rom_buf) begin
                    w_attempts   = c_max_att;
                    w_state_next = ST_PASSED;
                end else begin
                    w_fail     = 1'b1;
                    w_attempts = r_attempts - 4'd1;
                    if (r_attempts == 4'd1) begin
                        w_logout     = 1'b1;
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = c_lock_load;
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_user_buf   = '0;
                        w_rom_buf    = '0;
                        w_digit_cnt  = '0;
                        w_state_next = ST_ENTRY;
                    end
                end
            end

            ST_PASSED: begin
                if (gm_logout) begin
                    w_logout     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_login = 1'b1;
                end
            end

            ST_LOCKED: begin
                if (w_tmr_expired) begin
                    w_attempts   = c_max_att;
                    w_state_next = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_id         = '0;
                w_user_buf   = '0;
                w_rom_buf    = '0;
                w_digit_cnt  = '0;
                w_idx        = '0;
                w_wait       = '0;
                w_rom_addr   = '0;
                w_attempts   = c_max_att;
            end
        endcase
    end

    assign rom_addr      = r_rom_addr;
    assign login         = r_login;
    assign logout        = r_logout;
    assign fail          = r_fail;
    assign locked        = (r_state == ST_LOCKED);
    assign attempts_left = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_pass_auth_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pass_auth_engine
// Brief    : Directed self-checking bench for pass_auth_engine (default and
//            DIGITS=6/ROM_LAT=4 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pass_auth_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       ge_a, mid_a, guest_a, gml_a;
    logic [3:0] ud_a;
    logic [4:0] iid_a;
    logic [6:0] rom_addr_a;
    logic [3:0] rom_data_a;
    logic       login_a, logout_a, fail_a, locked_a;
    logic [3:0] att_a;

    // Instance B: DIGITS=6, ROM_LAT=4
    logic       ge_b, mid_b, guest_b, gml_b;
    logic [3:0] ud_b;
    logic [4:0] iid_b;
    logic [7:0] rom_addr_b;
    logic [3:0] rom_data_b;
    logic       login_b, logout_b, fail_b, locked_b;
    logic [3:0] att_b;

    pass_auth_engine dut_a (
        .clk(clk), .rst(rst), .game_enter(ge_a), .user_digit(ud_a),
        .matched_id(mid_a), .internal_id(iid_a), .guest(guest_a),
        .gm_logout(gml_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .login(login_a), .logout(logout_a), .fail(fail_a),
        .locked(locked_a), .attempts_left(att_a)
    );

    pass_auth_engine #(.DIGITS(6), .ROM_LAT(4)) dut_b (
        .clk(clk), .rst(rst), .game_enter(ge_b), .user_digit(ud_b),
        .matched_id(mid_b), .internal_id(iid_b), .guest(guest_b),
        .gm_logout(gml_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .login(login_b), .logout(logout_b), .fail(fail_b),
        .locked(locked_b), .attempts_left(att_b)
    );

    // ROM models: data for an address is sampled ROM_LAT edges after it is presented
    logic [3:0] mem_a [0:127];
    logic [3:0] mem_b [0:255];
    logic [6:0] pa1;
    logic [7:0] pb1, pb2, pb3;
    always @(posedge clk) begin
        pa1 <= rom_addr_a;
        pb1 <= rom_addr_b;
        pb2 <= pb1;
        pb3 <= pb2;
    end
    assign rom_data_a = mem_a[pa1];
    assign rom_data_b = mem_b[pb3];

    int n_fail_a = 0, n_logout_a = 0, n_addr_chg_a = 0, n_logout_b = 0, n_fail_b = 0;
    logic [6:0] prev_addr_a = '0;
    always @(negedge clk) begin
        if (fail_a)   n_fail_a++;
        if (logout_a) n_logout_a++;
        if (fail_b)   n_fail_b++;
        if (logout_b) n_logout_b++;
        if (rom_addr_a !== prev_addr_a) n_addr_chg_a++;
        prev_addr_a = rom_addr_a;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        mid_a = 1'b1; iid_a = 5'd3; tick(); mid_a = 1'b0;
    endtask

    task automatic enter_a(input logic [3:0] d);
        ge_a = 1'b1; ud_a = d; tick(); ge_a = 1'b0; ud_a = '0;
    endtask

    task automatic enter_b(input logic [3:0] d);
        ge_b = 1'b1; ud_b = d; tick(); ge_b = 1'b0; ud_b = '0;
    endtask

    task automatic wait_login_a(output int k);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (login_a) begin k = i; break; end
        end
    endtask

    task automatic wait_fail_a(output int k);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (fail_a) begin k = i; break; end
        end
    endtask

    task automatic logout_a_session();
        gml_a = 1'b1; tick(); gml_a = 1'b0;
        check("logout_pulse_hi", logout_a, 1);
        check("login_drop", login_a, 0);
        tick();
        check("logout_pulse_lo", logout_a, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k, snap_f, snap_l, snap_c, nlock;
        rst = 1'b1;
        ge_a = 0; ud_a = 0; mid_a = 0; iid_a = 0; guest_a = 0; gml_a = 0;
        ge_b = 0; ud_b = 0; mid_b = 0; iid_b = 0; guest_b = 0; gml_b = 0;
        for (int i = 0; i < 128; i++) mem_a[i] = 4'(i * 7 + 5);
        for (int i = 0; i < 256; i++) mem_b[i] = 4'(i * 11 + 9);
        mem_a[12] = 4'd1; mem_a[13] = 4'd2; mem_a[14] = 4'd3; mem_a[15] = 4'd4;
        for (int i = 0; i < 6; i++) mem_b[18 + i] = 4'(i + 1);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_login", login_a, 0);
        check("rst_logout", logout_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_locked", locked_a, 0);
        check("rst_rom_addr", rom_addr_a, 0);
        check("rst_attempts", att_a, 4);
        check("rst_attempts_b", att_b, 4);

        // Correct password, 14-cycle latency
        snap_f = n_fail_a;
        start_a();
        enter_a(1); enter_a(2); enter_a(3); enter_a(4);
        wait_login_a(k);
        check("latency_a", k, 14);
        check("pass_attempts", att_a, 4);
        check("pass_no_fail", n_fail_a - snap_f, 0);
        check("last_rom_addr", rom_addr_a, 15);
        enter_a(7); tick();
        check("enter_ignored_passed", login_a, 1);
        snap_l = n_logout_a;
        logout_a_session();
        check("logout_count", n_logout_a - snap_l, 1);

        // gm_logout in IDLE has no effect
        gml_a = 1'b1; tick(); gml_a = 1'b0; tick();
        check("gm_logout_idle", n_logout_a - snap_l, 1);

        // Four wrong attempts -> lockout
        snap_f = n_fail_a; snap_l = n_logout_a;
        start_a();
        for (int r = 0; r < 4; r++) begin
            enter_a(1); enter_a(2); enter_a(3); enter_a(5);
            wait_fail_a(k);
            check("fail_seen", (k != 0), 1);
            check("attempts_dec", att_a, 32'(3 - r));
            check("locked_flag", locked_a, (r == 3));
            check("logout_on_lock", logout_a, (r == 3));
        end
        nlock = 1;
        guest_a = 1'b1; mid_a = 1'b1; iid_a = 5'd3;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (nlock == 500) begin guest_a = 1'b0; mid_a = 1'b0; end
            if (!locked_a) break;
            nlock++;
        end
        guest_a = 1'b0; mid_a = 1'b0;
        check("locked_cycles", nlock, 1000);
        check("attempts_reload", att_a, 4);
        tick(); tick();
        check("guest_ignored_locked", login_a, 0);
        check("lock_fail_count", n_fail_a - snap_f, 4);
        check("lock_logout_count", n_logout_a - snap_l, 1);

        // Guest priority over matched_id, no ROM access
        snap_c = n_addr_chg_a; snap_l = n_logout_a;
        guest_a = 1'b1; mid_a = 1'b1; iid_a = 5'd3; tick();
        guest_a = 1'b0; mid_a = 1'b0;
        tick();
        check("guest_login", login_a, 1);
        logout_a_session();
        tick();
        check("guest_no_rom", n_addr_chg_a - snap_c, 0);
        check("guest_logout_count", n_logout_a - snap_l, 1);

        // Entry timeout: 5000 idle cycles discard the partial entry
        snap_f = n_fail_a;
        start_a();
        enter_a(1); enter_a(2);
        repeat (5000) tick();
        enter_a(1); enter_a(2); enter_a(3); enter_a(4);
        wait_login_a(k);
        check("timeout_login", (k != 0), 1);
        check("timeout_attempts", att_a, 4);
        check("timeout_no_fail", n_fail_a - snap_f, 0);
        logout_a_session();

        // Digit arriving in the expiry cycle is kept
        snap_f = n_fail_a;
        start_a();
        enter_a(1); enter_a(2);
        repeat (4999) tick();
        enter_a(3); enter_a(4);
        wait_login_a(k);
        check("expiry_cycle_login", k, 14);
        check("expiry_no_fail", n_fail_a - snap_f, 0);
        logout_a_session();

        // Reset while waiting on the ROM
        start_a();
        enter_a(1); enter_a(2); enter_a(3); enter_a(4);
        tick();
        check("fetch_addr", rom_addr_a, 12);
        snap_f = n_fail_a; snap_l = n_logout_a;
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_addr", rom_addr_a, 0);
        check("midrst_login", login_a, 0);
        check("midrst_locked", locked_a, 0);
        check("midrst_attempts", att_a, 4);
        repeat (30) tick();
        check("midrst_no_login", login_a, 0);
        check("midrst_no_pulses", (n_fail_a - snap_f) + (n_logout_a - snap_l), 0);

        // DIGITS=6, ROM_LAT=4: 6*5+2 = 32 cycles
        mid_b = 1'b1; iid_b = 5'd3; tick(); mid_b = 1'b0;
        for (int d = 1; d <= 6; d++) enter_b(4'(d));
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (login_b) begin k = i; break; end
        end
        check("latency_b", k, 32);
        check("b_attempts", att_b, 4);
        check("b_last_addr", rom_addr_b, 23);
        check("b_no_fail", n_fail_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
